// File: rtl/lpm_divide_pkg.sv
// Shared definitions for the sequential LPM divider: FSM encoding,
// representation names and the iteration-counter width helper.
package lpm_divide_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam string RepUnsigned = "UNSIGNED";
  localparam string RepSigned   = "SIGNED";

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lpm_divide_step.sv
// One restoring-division step: shift in the next numerator bit, trial-subtract
// the divisor, keep the difference if non-negative, otherwise restore.
module lpm_divide_step #(
  parameter int unsigned Width = 8
) (
  input  logic [Width:0]   rem_i,
  input  logic             bit_i,
  input  logic [Width-1:0] div_i,
  output logic [Width:0]   rem_o,
  output logic             q_o
);

  logic [Width+1:0] trial;

  // Compare on the full shifted value; the kept result always fits Width+1 bits.
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {2'b00, div_i});
    rem_o = trial[Width:0] - (q_o ? {1'b0, div_i} : {(Width + 1){1'b0}});
  end

endmodule

// File: rtl/lpm_divide_seq.sv
// Iterative restoring divider, one quotient bit per enabled clock.
// Optional macro LPM_DIVIDE_OVERFLOW_EN adds the registered 'overflow' output.
module lpm_divide_seq
  import lpm_divide_pkg::*;
#(
  parameter int unsigned lpm_widthn         = 8,
  parameter int unsigned lpm_widthd         = 8,
  parameter string       lpm_representation = "UNSIGNED",
  parameter string       lpm_hint           = "UNUSED"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clken,
  input  logic                  start,
  input  logic [lpm_widthn-1:0] numer,
  input  logic [lpm_widthd-1:0] denom,
  output logic                  busy,
  output logic                  done,
  output logic [lpm_widthn-1:0] quotient,
  output logic [lpm_widthd-1:0] remain,
  output logic                  div_by_zero
`ifdef LPM_DIVIDE_OVERFLOW_EN
  ,
  output logic                  overflow
`endif
);

  localparam int unsigned WN       = lpm_widthn;
  localparam int unsigned WD       = lpm_widthd;
  localparam int unsigned CntW     = cnt_width(lpm_widthn);
  localparam bit          IsSigned = (lpm_representation == RepSigned);

  if ((lpm_representation != RepSigned) && (lpm_representation != RepUnsigned)) begin : g_bad_rep
    $error("lpm_divide_seq: unsupported lpm_representation \"%s\" (lpm_hint \"%s\")",
           lpm_representation, lpm_hint);
  end

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WN-1:0]   num_q, num_d;     // numerator magnitude, becomes quotient magnitude
  logic [WD:0]     rem_q, rem_d;     // partial remainder
  logic [WD-1:0]   dmag_q, dmag_d;
  logic            neg_n_q, neg_n_d, neg_d_q, neg_d_d, dz_q, dz_d;
  logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WN-1:0]   quo_q, quo_d;
  logic [WD-1:0]   remo_q, remo_d;
`ifdef LPM_DIVIDE_OVERFLOW_EN
  localparam logic [WN-1:0] MinN = {1'b1, {(WN - 1){1'b0}}};
  logic            ovp_q, ovp_d, ovf_q, ovf_d;
`endif

  logic            sn, sd;
  logic [WN-1:0]   nmag;
  logic [WD-1:0]   dmag;
  logic [WD:0]     step_rem;
  logic            step_q;

  lpm_divide_step #(
    .Width (WD)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (num_q[WN-1]),
    .div_i (dmag_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state logic: operand capture in IDLE, iteration in CALC, sign fix-up in FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    neg_n_d = neg_n_q;
    neg_d_d = neg_d_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
`ifdef LPM_DIVIDE_OVERFLOW_EN
    ovp_d   = ovp_q;
    ovf_d   = ovf_q;
`endif
    sn   = IsSigned && numer[WN-1];
    sd   = IsSigned && denom[WD-1];
    nmag = sn ? (~numer + 1'b1) : numer;
    dmag = sd ? (~denom + 1'b1) : denom;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_n_d = sn;
          neg_d_d = sd;
          dmag_d  = dmag;
          rem_d   = '0;
          busy_d  = 1'b1;
          dz_d    = (denom == '0);
`ifdef LPM_DIVIDE_OVERFLOW_EN
          ovp_d   = IsSigned && (numer == MinN) && (denom == '1);
`endif
          if (denom == '0) begin
            // Raw numerator kept so its low bits can be returned as the remainder.
            num_d   = numer;
            state_d = FIX;
          end else begin
            num_d   = nmag;
            cnt_d   = CntW'(WN);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        num_d = {num_q[WN-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          quo_d  = '1;
          remo_d = num_q[WD-1:0];
        end else begin
          quo_d  = (neg_n_q ^ neg_d_q) ? (~num_q + 1'b1) : num_q;
          remo_d = neg_n_q ? (~rem_q[WD-1:0] + 1'b1) : rem_q[WD-1:0];
        end
        dbz_d   = dz_q;
`ifdef LPM_DIVIDE_OVERFLOW_EN
        ovf_d   = dz_q | ovp_q;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers: async clear, everything frozen while clken is low.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      neg_n_q <= 1'b0;
      neg_d_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
`ifdef LPM_DIVIDE_OVERFLOW_EN
      ovp_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else if (clken) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      neg_n_q <= neg_n_d;
      neg_d_q <= neg_d_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
`ifdef LPM_DIVIDE_OVERFLOW_EN
      ovp_q   <= ovp_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remain      = remo_q;
  assign div_by_zero = dbz_q;
`ifdef LPM_DIVIDE_OVERFLOW_EN
  assign overflow    = ovf_q;
`endif

endmodule

// File: doc/lpm_divide_seq.md
Name: lpm_divide_seq

Overview:
Iterative restoring divider built on the same subtract-and-compare primitive as the team's LPM add/sub block; it is the inverse arithmetic path, recovering quotient and remainder by repeated subtraction.
- One quotient bit per enabled clock; start/busy/done handshake.
- Used where a combinational divider is too large, e.g. scaling counters or averaging sums produced by the adder datapath.
- Supports both UNSIGNED and SIGNED representation, selected by parameter.

Parameters:
- lpm_widthn, 8: numerator and quotient width, ≥ 2.
- lpm_widthd, 8: denominator and remainder width, ≥ 2, ≤ lpm_widthn.
- lpm_representation, "UNSIGNED": "UNSIGNED" or "SIGNED". Any other value prints an error message at elaboration/initial time.
- lpm_hint, "UNUSED": ignored; kept for LPM compatibility.

Ports:
- clock  in  1  sole clock, rising edge.
- aclr  in  1  asynchronous, active-high reset; defaults to 0 when unconnected.
- clken  in  1  clock enable; defaults to 1 when unconnected.
- start  in  1  request a division; sampled on a clock edge when clken=1.
- numer  in  lpm_widthn  numerator; latched on the accepted start.
- denom  in  lpm_widthd  denominator; latched on the accepted start.
- busy  out  1  division in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  lpm_widthn  result quotient; held until the next done.
- remain  out  lpm_widthd  result remainder; held until the next done.
- div_by_zero  out  1  set with done when the latched denominator was 0.

Behaviour:
- Reset: aclr=1 forces state IDLE, counter 0, and busy, done, quotient, remain and div_by_zero all to 0, immediately. Aborts any operation in progress; no done is produced for it.
- clken=0: every register holds, including the done level; state, counter and outputs are frozen.
- States: IDLE, CALC, FIX.
- IDLE, start=1 (edge E0):
  - latch operands and signs;
  - form unsigned magnitudes (two's-complement negate when SIGNED and MSB=1);
  - busy goes to 1, done goes to 0;
  - if denom=0, go to FIX; otherwise go to CALC with counter=lpm_widthn.
- CALC: each enabled edge shifts the next numerator bit into a (lpm_widthd+1)-bit partial remainder, then trial-subtracts the denominator magnitude.
  - If the result is non-negative, keep it and the quotient bit is 1; otherwise restore and the quotient bit is 0.
  - Decrement the counter; when it reaches 0, go to FIX.
- FIX: a single edge.
  - SIGNED: negate the quotient if the operand signs differ; the remainder takes the numerator's sign (truncation toward zero).
  - Register quotient, remain and div_by_zero; done=1 for one enabled cycle; busy=0; go to IDLE.
- Latency: done is high after edge E0+lpm_widthn+1 for a nonzero divisor, and after E0+1 for a zero divisor.
- start while busy=1 is ignored. start in the done cycle is accepted (state is already IDLE).
- Divide by zero: quotient=all ones, remain=numer[lpm_widthd-1:0], div_by_zero=1.
- SIGNED most-negative / -1: quotient wraps to most-negative, remain=0, no error.
- Width rule: quotient is exact modulo 2^lpm_widthn; |remain| < |denom| always holds.
- Outputs are never X after reset; numer/denom changes outside the accepted start have no effect.

Optional Feature:
- Macro LPM_DIVIDE_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), registered in FIX alongside done. It is set for SIGNED most-negative/-1 and for division by zero; it is 0 otherwise and 0 at reset.
- Undefined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Package lpm_divide_pkg holds:
  - state encoding constants IDLE/CALC/FIX;
  - representation string constants;
  - a counter-width function ceil(log2(lpm_widthn+1)).
- One natural sub-module, lpm_divide_step: purely combinational shift, trial-subtract and restore for one bit. Inputs are partial remainder, numerator bit and divisor; outputs are the new remainder and the quotient bit. Instantiated once inside the sequential shell.

Test Plan:
- UNSIGNED 8/8, numer=200, denom=7, start at E0 → busy for 9 edges, done after E9, quotient=28, remain=4, div_by_zero=0.
- SIGNED 8/8, numer=-100 (0x9C), denom=7 → quotient=-14 (0xF2), remain=-2 (0xFE); then numer=100, denom=-7 → quotient=0xF2, remain=2.
- denom=0, numer=0x5A → done after E1, quotient=0xFF, remain=0x5A, div_by_zero=1; overflow=1 when LPM_DIVIDE_OVERFLOW_EN is defined.
- Pulse aclr at counter=3 mid-CALC → all outputs 0 immediately, no done. Then 15/4 → quotient=3, remain=3.
- Hold clken=0 for 5 cycles mid-CALC → done is delayed exactly 5 cycles with correct results. Issue start during busy → ignored. Issue start in the done cycle (50/5) → accepted, quotient=10, remain=0.
- SIGNED -128/-1 → quotient=0x80, remain=0, div_by_zero=0; overflow=1 when the macro is defined.
